alu_op_dispatcher: RTL

//   Initiator side of the ALU unit interface. Accepts one operation request (A, B, 4-bit function) over valid/ready.

---
 rtl/alu_op_dispatcher.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/alu_op_dispatcher.sv
// Initiator side of the ALU unit interface: accepts one request, enables one unit for a cycle,
// captures that unit's registered result and hands it back over a valid/ready response port.
module alu_op_dispatcher #(
    parameter int Operand_SIZE = 16,
    parameter int ALU_OUT      = 32
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    REQ_VALID,
    output logic                    REQ_READY,
    input  logic [Operand_SIZE-1:0] REQ_A,
    input  logic [Operand_SIZE-1:0] REQ_B,
    input  logic [3:0]              REQ_FUN,
    output logic [Operand_SIZE-1:0] A,
    output logic [Operand_SIZE-1:0] B,
    output logic [1:0]              ALU_FUN,
    output logic                    ARITH_Enable,
    output logic                    LOGIC_Enable,
    output logic                    CMP_Enable,
    output logic                    SHIFT_Enable,
    input  logic [ALU_OUT-1:0]      ARITH_OUT,
    input  logic [ALU_OUT-1:0]      LOGIC_OUT,
    input  logic [ALU_OUT-1:0]      CMP_OUT,
    input  logic [ALU_OUT-1:0]      SHIFT_OUT,
    input  logic                    ARITH_Flag,
    input  logic                    LOGIC_Flag,
    input  logic                    CMP_Flag,
    input  logic                    SHIFT_Flag,
    output logic                    RES_VALID,
    input  logic                    RES_READY,
    output logic [ALU_OUT-1:0]      RES_OUT,
    output logic [1:0]              RES_UNIT,
    output logic                    RES_ERR,
    output logic [15:0]             OP_COUNT
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    state_t state_reg, state_next;

    logic [Operand_SIZE-1:0] a_reg, b_reg;
    logic [1:0]              fun_reg, sel_reg, res_unit_reg;
    logic [3:0]              en_reg, en_next;
    logic [ALU_OUT-1:0]      res_out_reg;
    logic                    res_err_reg;
    logic [15:0]             op_count_reg;

    logic [ALU_OUT-1:0]      unit_out [4];
    logic [3:0]              unit_flag;
    logic                    accept, resp_done;

    assign unit_out[0] = ARITH_OUT;
    assign unit_out[1] = LOGIC_OUT;
    assign unit_out[2] = CMP_OUT;
    assign unit_out[3] = SHIFT_OUT;
    assign unit_flag   = {SHIFT_Flag, CMP_Flag, LOGIC_Flag, ARITH_Flag};

    assign accept    = (state_reg == S_IDLE) && REQ_VALID;
    assign resp_done = (state_reg == S_RESP) && RES_READY;

    // The enable register is loaded on accept, so it is high exactly for the ISSUE cycle.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_en
            assign en_next[gi] = accept && (REQ_FUN[3:2] == 2'(gi));
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:    if (accept) state_next = S_ISSUE;
            S_ISSUE:   state_next = S_CAPTURE;
            S_CAPTURE: state_next = S_RESP;
            S_RESP:    if (resp_done) state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            a_reg        <= '0;
            b_reg        <= '0;
            fun_reg      <= '0;
            sel_reg      <= '0;
            en_reg       <= '0;
            res_out_reg  <= '0;
            res_unit_reg <= '0;
            res_err_reg  <= 1'b0;
            op_count_reg <= '0;
        end else begin
            en_reg <= en_next;
            if (accept) begin
                a_reg   <= REQ_A;
                b_reg   <= REQ_B;
                fun_reg <= REQ_FUN[1:0];
                sel_reg <= REQ_FUN[3:2];
            end
            if (state_reg == S_ISSUE) begin
                res_err_reg <= ~unit_flag[sel_reg];
            end
            // Only the selected unit is sampled, so deselected units cannot disturb the result.
            if (state_reg == S_CAPTURE) begin
                res_out_reg  <= unit_out[sel_reg];
                res_unit_reg <= sel_reg;
            end
            if (resp_done && (op_count_reg != 16'hFFFF)) begin
                op_count_reg <= op_count_reg + 16'd1;
            end
        end
    end

    assign REQ_READY    = (state_reg == S_IDLE);
    assign RES_VALID    = (state_reg == S_RESP);
    assign A            = a_reg;
    assign B            = b_reg;
    assign ALU_FUN      = fun_reg;
    assign ARITH_Enable = en_reg[0];
    assign LOGIC_Enable = en_reg[1];
    assign CMP_Enable   = en_reg[2];
    assign SHIFT_Enable = en_reg[3];
    assign RES_OUT      = res_out_reg;
    assign RES_UNIT     = res_unit_reg;
    assign RES_ERR      = res_err_reg;
    assign OP_COUNT     = op_count_reg;

endmodule
